rename_reg_file: RTL

- Architectural register file with per-register rename state (busy flag plus ROB tag), for the out-of-order core.
- Successor of the single-commit, two-read, flush-less register file. Adds:
  - parametrised read-port count;
  - parametrised commit-port count;
  - global flush on misprediction;
  - same-cycle commit-to-read bypass.
- Sits between the decoder (reads operands, renames rd) and the ROB (commits results, issues flush).

---
 rtl/rename_reg_file_pkg.sv | 15 +
 rtl/rename_reg_file_rf_read_port.sv | 45 ++++
 rtl/rename_reg_file.sv | 96 +++++++++
 3 files changed

// File: rtl/rename_reg_file_pkg.sv
// Shared defaults and constants for the rename-aware architectural register file.
package rename_reg_file_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_NREGS  = 32;
   localparam int unsigned DEF_REG_W  = 5;
   localparam int unsigned DEF_ROB_W  = 4;

   // ROB tag 0 means "no in-flight producer".
   localparam int unsigned ZERO_ROB = 0;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

endpackage

// File: rtl/rename_reg_file_rf_read_port.sv
// One combinational read lane: reg-0 check, commit bypass, then stored rename state.
module rf_read_port
   import rename_reg_file_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NREGS    = DEF_NREGS,
   parameter int unsigned REG_W    = DEF_REG_W,
   parameter int unsigned ROB_W    = DEF_ROB_W,
   parameter int unsigned N_COMMIT = 1
) (
   input  logic                           ena_i,
   input  logic [REG_W-1:0]               idx_i,
   input  logic [NREGS-1:1][DATA_W-1:0]   data_i,
   input  logic [NREGS-1:1][ROB_W-1:0]    tag_i,
   input  logic [NREGS-1:1]               busy_i,
   input  logic [N_COMMIT-1:0]            cm_ena_i,
   input  logic [N_COMMIT*REG_W-1:0]      cm_reg_i,
   input  logic [N_COMMIT*ROB_W-1:0]      cm_tag_i,
   input  logic [N_COMMIT*DATA_W-1:0]     cm_value_i,
   output logic [DATA_W-1:0]              value_o,
   output logic [ROB_W-1:0]               tag_o,
   output logic                           busy_o
);

   always_comb begin
      value_o = '0;
      tag_o   = ROB_W'(ZERO_ROB);
      busy_o  = FALSE;
      if (idx_i != '0 && int'(idx_i) < int'(NREGS)) begin
         value_o = data_i[idx_i];
         tag_o   = tag_i[idx_i];
         busy_o  = busy_i[idx_i];
         // Ascending loop so the highest matching commit port wins.
         for (int c = 0; c < int'(N_COMMIT); c++) begin
            if (ena_i && cm_ena_i[c] && cm_reg_i[c*REG_W +: REG_W] == idx_i &&
                cm_tag_i[c*ROB_W +: ROB_W] == tag_i[idx_i]) begin
               value_o = cm_value_i[c*DATA_W +: DATA_W];
               tag_o   = ROB_W'(ZERO_ROB);
               busy_o  = FALSE;
            end
         end
      end
   end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with busy/ROB-tag rename state, multi-port commit and flush.
module rename_reg_file
   import rename_reg_file_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NREGS    = DEF_NREGS,
   parameter int unsigned REG_W    = DEF_REG_W,
   parameter int unsigned ROB_W    = DEF_ROB_W,
   parameter int unsigned N_READ   = 2,
   parameter int unsigned N_COMMIT = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ena,
   input  logic [N_READ*REG_W-1:0]    rd_idx,
   output logic [N_READ*DATA_W-1:0]   rd_value,
   output logic [N_READ*ROB_W-1:0]    rd_tag,
   output logic [N_READ-1:0]          rd_busy,
   input  logic                       occ_ena,
   input  logic [REG_W-1:0]           occ_reg,
   input  logic [ROB_W-1:0]           occ_tag,
   input  logic [N_COMMIT-1:0]        cm_ena,
   input  logic [N_COMMIT*REG_W-1:0]  cm_reg,
   input  logic [N_COMMIT*ROB_W-1:0]  cm_tag,
   input  logic [N_COMMIT*DATA_W-1:0] cm_value,
   input  logic                       flush
);

   logic [NREGS-1:1][DATA_W-1:0] data_q, data_d;
   logic [NREGS-1:1][ROB_W-1:0]  tag_q, tag_d;
   logic [NREGS-1:1]             busy_q, busy_d;

   always_comb begin
      data_d = data_q;
      tag_d  = tag_q;
      busy_d = busy_q;
      // Later ports overwrite earlier ones, so the highest port decides data and clear.
      for (int r = 1; r < int'(NREGS); r++) begin
         for (int c = 0; c < int'(N_COMMIT); c++) begin
            if (ena && cm_ena[c] && int'(cm_reg[c*REG_W +: REG_W]) == r) begin
               data_d[r] = cm_value[c*DATA_W +: DATA_W];
               if (cm_tag[c*ROB_W +: ROB_W] == tag_q[r]) begin
                  tag_d[r]  = ROB_W'(ZERO_ROB);
                  busy_d[r] = FALSE;
               end else begin
                  tag_d[r]  = tag_q[r];
                  busy_d[r] = busy_q[r];
               end
            end
         end
      end
      if (flush) begin
         tag_d  = '0;
         busy_d = '0;
      end else if (ena && occ_ena && occ_reg != '0 && int'(occ_reg) < int'(NREGS)) begin
         tag_d[occ_reg]  = occ_tag;
         busy_d[occ_reg] = TRUE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         tag_q  <= '0;
         busy_q <= '0;
      end else begin
         data_q <= data_d;
         tag_q  <= tag_d;
         busy_q <= busy_d;
      end
   end

   for (genvar i = 0; i < int'(N_READ); i++) begin : g_rd
      rf_read_port #(
         .DATA_W   (DATA_W),
         .NREGS    (NREGS),
         .REG_W    (REG_W),
         .ROB_W    (ROB_W),
         .N_COMMIT (N_COMMIT)
      ) u_port (
         .ena_i      (ena),
         .idx_i      (rd_idx[i*REG_W +: REG_W]),
         .data_i     (data_q),
         .tag_i      (tag_q),
         .busy_i     (busy_q),
         .cm_ena_i   (cm_ena),
         .cm_reg_i   (cm_reg),
         .cm_tag_i   (cm_tag),
         .cm_value_i (cm_value),
         .value_o    (rd_value[i*DATA_W +: DATA_W]),
         .tag_o      (rd_tag[i*ROB_W +: ROB_W]),
         .busy_o     (rd_busy[i])
      );
   end

endmodule
